sr_chain_loader: RTL

// - Parametrised successor to the fixed static/dynamic shift-register loader.
// - Captures a static word (SIZESRSTAT bits) and a dynamic word (SIZESRDYN bits) on a command handshake.
// - Serialises them onto one data line with a divided shift strobe, then pulses a latch per register.
// - Mirrors the latched values on shadow outputs. Sits between the control FSM and the external shift-register chain.

---
 rtl/sr_chain_loader_if.sv | 32 +++
 rtl/sr_chain_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_chain_loader_if.sv
// ----------------------------------------------------------------------------
// sr_chain_loader_if
// Command handshake between the control FSM (master) and sr_chain_loader
// (slave).
//   cmd_valid  master -> slave  load request
//   cmd_mode   master -> slave  1: static then dynamic, 0: dynamic only
//   STATREG    master -> slave  static word, sampled when the command is accepted
//   DYNREG     master -> slave  dynamic word, sampled when the command is accepted
//   cmd_ready  slave -> master  high only while the loader is idle
//   done       slave -> master  one-cycle pulse at the end of a command
// ----------------------------------------------------------------------------
interface sr_chain_loader_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) ();
    logic                  cmd_valid;
    logic                  cmd_mode;
    logic                  cmd_ready;
    logic                  done;
    logic [SIZESRSTAT-1:0] STATREG;
    logic [SIZESRDYN-1:0]  DYNREG;

    modport master (
        output cmd_valid, cmd_mode, STATREG, DYNREG,
        input  cmd_ready, done
    );

    modport slave (
        input  cmd_valid, cmd_mode, STATREG, DYNREG,
        output cmd_ready, done
    );
endinterface

// File: rtl/sr_chain_loader.sv
// ----------------------------------------------------------------------------
// sr_chain_loader
// Captures a static and a dynamic word on a command handshake, shifts them out
// on a single data line with a divided shift strobe, pulses a latch for each
// register, and keeps shadow copies of the last latched words.
//
// Ports
//   CLK, RST_N    clock, asynchronous active-low reset
//   cmd           command handshake (slave side of sr_chain_loader_if)
//   sdo           serial data, changes only at bit boundaries
//   sclk          shift strobe, external register samples sdo on its rise
//   sel_stat      high while shifting or latching the static word
//   sel_dyn       high while shifting or latching the dynamic word
//   stat_latch    static latch pulse (LATCH_W cycles)
//   dyn_latch     dynamic latch pulse (LATCH_W cycles)
//   STATLATCH     shadow of the last latched static word
//   DYNLATCH      shadow of the last latched dynamic word
//
// Every output is a flop. They are loaded from the next-state values, so the
// outputs belonging to a state are visible in the same cycle the state is.
// ----------------------------------------------------------------------------
module sr_chain_loader #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CLKDIV     = 4,
    parameter int LATCH_W    = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    sr_chain_loader_if.slave      cmd,
    output logic                  sdo,
    output logic                  sclk,
    output logic                  sel_stat,
    output logic                  sel_dyn,
    output logic                  stat_latch,
    output logic                  dyn_latch,
    output logic [SIZESRSTAT-1:0] STATLATCH,
    output logic [SIZESRDYN-1:0]  DYNLATCH
);

    localparam int MAXSIZE = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int BW = (MAXSIZE > 1) ? $clog2(MAXSIZE) : 1;
    localparam int DW = $clog2(CLKDIV);
    localparam int LW = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;

    localparam logic [BW-1:0] STAT_LAST = BW'(SIZESRSTAT - 1);
    localparam logic [BW-1:0] DYN_LAST  = BW'(SIZESRDYN - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLKDIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLKDIV / 2);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_W - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SH_STAT  = 3'd1;
    localparam logic [2:0] S_LAT_STAT = 3'd2;
    localparam logic [2:0] S_SH_DYN   = 3'd3;
    localparam logic [2:0] S_LAT_DYN  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]            r_state;
    logic [DW-1:0]         r_div;
    logic [BW-1:0]         r_bit;
    logic [LW-1:0]         r_lat;
    logic [SIZESRSTAT-1:0] r_statSh;
    logic [SIZESRDYN-1:0]  r_dynSh;
    logic [SIZESRSTAT-1:0] r_statCap;
    logic [SIZESRDYN-1:0]  r_dynCap;
    logic [SIZESRSTAT-1:0] r_statShadow;
    logic [SIZESRDYN-1:0]  r_dynShadow;
    logic                  r_sdo;
    logic                  r_sclk;
    logic                  r_selStat;
    logic                  r_selDyn;
    logic                  r_statLatch;
    logic                  r_dynLatch;
    logic                  r_done;
    logic                  r_ready;

    logic [2:0]            w_nextState;
    logic [DW-1:0]         w_nextDiv;
    logic [BW-1:0]         w_nextBit;
    logic [LW-1:0]         w_nextLat;
    logic [SIZESRSTAT-1:0] w_nextStatSh;
    logic [SIZESRDYN-1:0]  w_nextDynSh;
    logic                  w_accept;
    logic                  w_statOut;
    logic                  w_dynOut;
    logic                  w_nextShifting;

    // Next-state logic. The shift registers always present the bit currently
    // on the line at their output end, and advance only when the divider wraps
    // and another bit of the same word remains.
    always_comb begin
        w_nextState  = r_state;
        w_nextDiv    = r_div;
        w_nextBit    = r_bit;
        w_nextLat    = r_lat;
        w_nextStatSh = r_statSh;
        w_nextDynSh  = r_dynSh;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_nextState  = cmd.cmd_mode ? S_SH_STAT : S_SH_DYN;
                    w_nextDiv    = '0;
                    w_nextBit    = '0;
                    w_nextStatSh = cmd.STATREG;
                    w_nextDynSh  = cmd.DYNREG;
                end
            end
            S_SH_STAT: begin
                if (r_div == DIV_LAST) begin
                    w_nextDiv = '0;
                    if (r_bit == STAT_LAST) begin
                        w_nextState = S_LAT_STAT;
                        w_nextLat   = '0;
                    end else begin
                        w_nextBit    = r_bit + 1'b1;
                        w_nextStatSh = (MSB_FIRST != 0) ? (r_statSh << 1) : (r_statSh >> 1);
                    end
                end else begin
                    w_nextDiv = r_div + 1'b1;
                end
            end
            S_LAT_STAT: begin
                if (r_lat == LAT_LAST) begin
                    w_nextState = S_SH_DYN;
                    w_nextDiv   = '0;
                    w_nextBit   = '0;
                end else begin
                    w_nextLat = r_lat + 1'b1;
                end
            end
            S_SH_DYN: begin
                if (r_div == DIV_LAST) begin
                    w_nextDiv = '0;
                    if (r_bit == DYN_LAST) begin
                        w_nextState = S_LAT_DYN;
                        w_nextLat   = '0;
                    end else begin
                        w_nextBit   = r_bit + 1'b1;
                        w_nextDynSh = (MSB_FIRST != 0) ? (r_dynSh << 1) : (r_dynSh >> 1);
                    end
                end else begin
                    w_nextDiv = r_div + 1'b1;
                end
            end
            S_LAT_DYN: begin
                if (r_lat == LAT_LAST) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextLat = r_lat + 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_statOut      = (MSB_FIRST != 0) ? w_nextStatSh[SIZESRSTAT-1] : w_nextStatSh[0];
    assign w_dynOut       = (MSB_FIRST != 0) ? w_nextDynSh[SIZESRDYN-1]   : w_nextDynSh[0];
    assign w_nextShifting = (w_nextState == S_SH_STAT) || (w_nextState == S_SH_DYN);

    // State, counters and registered outputs. A reset at any point clears the
    // shadows too, so a partially shifted word can never reach them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_lat        <= '0;
            r_statSh     <= '0;
            r_dynSh      <= '0;
            r_statCap    <= '0;
            r_dynCap     <= '0;
            r_statShadow <= '0;
            r_dynShadow  <= '0;
            r_sdo        <= 1'b0;
            r_sclk       <= 1'b0;
            r_selStat    <= 1'b0;
            r_selDyn     <= 1'b0;
            r_statLatch  <= 1'b0;
            r_dynLatch   <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_div    <= w_nextDiv;
            r_bit    <= w_nextBit;
            r_lat    <= w_nextLat;
            r_statSh <= w_nextStatSh;
            r_dynSh  <= w_nextDynSh;
            if (w_accept) begin
                r_statCap <= cmd.STATREG;
                r_dynCap  <= cmd.DYNREG;
            end
            if ((r_state == S_SH_STAT) && (w_nextState == S_LAT_STAT)) begin
                r_statShadow <= r_statCap;
            end
            if ((r_state == S_SH_DYN) && (w_nextState == S_LAT_DYN)) begin
                r_dynShadow <= r_dynCap;
            end
            r_sdo       <= (w_nextState == S_SH_STAT) ? w_statOut :
                           (w_nextState == S_SH_DYN)  ? w_dynOut  : 1'b0;
            r_sclk      <= w_nextShifting && (w_nextDiv >= DIV_HALF);
            r_selStat   <= (w_nextState == S_SH_STAT) || (w_nextState == S_LAT_STAT);
            r_selDyn    <= (w_nextState == S_SH_DYN)  || (w_nextState == S_LAT_DYN);
            r_statLatch <= (w_nextState == S_LAT_STAT);
            r_dynLatch  <= (w_nextState == S_LAT_DYN);
            r_done      <= (w_nextState == S_DONE);
            r_ready     <= (w_nextState == S_IDLE);
        end
    end

    assign sdo           = r_sdo;
    assign sclk          = r_sclk;
    assign sel_stat      = r_selStat;
    assign sel_dyn       = r_selDyn;
    assign stat_latch    = r_statLatch;
    assign dyn_latch     = r_dynLatch;
    assign STATLATCH     = r_statShadow;
    assign DYNLATCH      = r_dynShadow;
    assign cmd.cmd_ready = r_ready;
    assign cmd.done      = r_done;

endmodule
